// File: rtl/route_pkg.sv
// Shared definitions for the router input stage.
package route_pkg;

  // Width of the saturating drop counter.
  localparam int DROP_W = 8;

  // Select width for n outputs; a single output still needs one select bit.
  function automatic int sel_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/route_fifo.sv
// Small circular FIFO: storage array, head/tail pointers and occupancy count.
// The caller guarantees enq_en only when !full and deq_en only when !empty.
module route_fifo #(
  parameter int p_nbits = 32,
  parameter int p_depth = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_en,
  input  logic [p_nbits-1:0] enq_msg,
  input  logic               deq_en,
  output logic [p_nbits-1:0] head_msg,
  output logic               empty,
  output logic               full
);

  localparam int PTR_W = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int CNT_W = $clog2(p_depth + 1);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(p_depth - 1);
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(p_depth);

  logic [p_nbits-1:0] entry_q [p_depth];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Next-state for pointers (wrapping at the last entry) and the count.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (deq_en) head_d = (head_q == LAST) ? '0 : head_q + 1'b1;
    if (enq_en) tail_d = (tail_q == LAST) ? '0 : tail_q + 1'b1;
    case ({enq_en, deq_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Packet storage; contents need no reset because the count guards reads.
  always_ff @(posedge clk) begin
    if (enq_en) entry_q[tail_q] <= enq_msg;
  end

  assign head_msg = entry_q[head_q];
  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH);

endmodule

// File: rtl/route_input_queue.sv
// Router input port: buffers packets, presents the head with its destination
// select to the output demux, and drops packets aimed at nonexistent outputs.
module route_input_queue
  import route_pkg::*;
#(
  parameter int p_nbits    = 32,
  parameter int p_noutputs = 4,
  parameter int p_depth    = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [p_nbits-1:0]                  recv_msg,
  input  logic                                recv_val,
  output logic                                recv_rdy,
  output logic [p_nbits-1:0]                  send_msg,
  output logic [route_pkg::sel_width(p_noutputs)-1:0] send_sel,
  output logic                                send_val,
  input  logic [p_noutputs-1:0]               send_rdy,
  output logic [DROP_W-1:0]                   drop_count
);

  localparam int SELW = sel_width(p_noutputs);
  localparam int RDYW = 1 << SELW;
  localparam logic [SELW:0] NOUT = (SELW + 1)'(p_noutputs);

  logic [p_nbits-1:0] head_msg;
  logic               empty, full;
  logic               enq_en, deq_en;
  logic               head_vld, legal;
  logic [SELW-1:0]    dest;
  logic [RDYW-1:0]    rdy_pad;
  logic [DROP_W-1:0]  drop_q, drop_d;

  route_fifo #(
    .p_nbits (p_nbits),
    .p_depth (p_depth)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .enq_en   (enq_en),
    .enq_msg  (recv_msg),
    .deq_en   (deq_en),
    .head_msg (head_msg),
    .empty    (empty),
    .full     (full)
  );

  // Destination lives in the top bits; codes at or above the output count are illegal.
  assign dest  = head_msg[p_nbits-1 -: SELW];
  assign legal = ({1'b0, dest} < NOUT);

  // Pad ready to the full select range so an illegal code never indexes out of range.
  assign rdy_pad = RDYW'(send_rdy);

  // Nothing is offered or accepted while reset is asserted.
  assign head_vld = !reset && !empty;
  assign recv_rdy = !reset && !full;
  assign enq_en   = recv_val && recv_rdy;

  // Legal heads leave when their output is ready; illegal heads leave at once.
  assign deq_en   = head_vld && (!legal || rdy_pad[dest]);
  assign send_val = head_vld && legal;
  assign send_msg = head_vld ? head_msg : '0;
  assign send_sel = head_vld ? dest : '0;

  // Count each dropped head, holding at the maximum value.
  always_comb begin
    drop_d = drop_q;
    if (head_vld && !legal && (drop_q != '1)) drop_d = drop_q + 1'b1;
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (reset) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  assign drop_count = drop_q;

endmodule

// File: tb/tb_route_input_queue.sv
// Directed bench: a vector table drives a 4-output instance; hand-written
// sequences drive a 3-output instance for illegal-destination drops.
module tb_route_input_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-output instance
  logic       rst4, val4, rr4, sv4;
  logic [7:0] msg4, smsg4, drop4;
  logic [3:0] srdy4;
  logic [1:0] sel4;

  // 3-output instance
  logic       rst3, val3, rr3, sv3;
  logic [7:0] msg3, smsg3, drop3;
  logic [2:0] srdy3;
  logic [1:0] sel3;

  route_input_queue #(.p_nbits(8), .p_noutputs(4), .p_depth(2)) u_dut4 (
    .clk(clk), .reset(rst4), .recv_msg(msg4), .recv_val(val4), .recv_rdy(rr4),
    .send_msg(smsg4), .send_sel(sel4), .send_val(sv4), .send_rdy(srdy4),
    .drop_count(drop4)
  );

  route_input_queue #(.p_nbits(8), .p_noutputs(3), .p_depth(2)) u_dut3 (
    .clk(clk), .reset(rst3), .recv_msg(msg3), .recv_val(val3), .recv_rdy(rr3),
    .send_msg(smsg3), .send_sel(sel3), .send_val(sv3), .send_rdy(srdy3),
    .drop_count(drop3)
  );

  typedef struct {
    logic       rst;
    logic       val;
    logic [7:0] msg;
    logic [3:0] srdy;
    logic       e_rr;
    logic       e_sv;
    logic [1:0] e_sel;
    logic [7:0] e_msg;
    logic [7:0] e_drop;
  } vec_t;

  vec_t vq[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input logic rst, input logic val, input logic [7:0] msg,
                     input logic [3:0] srdy, input logic err, input logic esv,
                     input logic [1:0] esel, input logic [7:0] emsg);
    vec_t v;
    v = '{rst: rst, val: val, msg: msg, srdy: srdy, e_rr: err, e_sv: esv,
          e_sel: esel, e_msg: emsg, e_drop: 8'h00};
    vq.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   drops_seen_val;
    vec_t v;

    // rst val msg   srdy     rr sv sel  msg
    add(1, 0, 8'h00, 4'b0000, 0, 0, 2'd0, 8'h00);   // reset state
    // basic transfer
    add(0, 1, 8'hC5, 4'b1000, 1, 0, 2'd0, 8'h00);
    add(0, 0, 8'h00, 4'b1000, 1, 1, 2'd3, 8'hC5);
    add(0, 0, 8'h00, 4'b0000, 1, 0, 2'd0, 8'h00);
    // backpressure then drain in order
    add(0, 1, 8'h41, 4'b0000, 1, 0, 2'd0, 8'h00);
    add(0, 1, 8'h82, 4'b0000, 1, 1, 2'd1, 8'h41);
    add(0, 1, 8'h13, 4'b0000, 0, 1, 2'd1, 8'h41);
    add(0, 1, 8'h13, 4'b1111, 0, 1, 2'd1, 8'h41);
    add(0, 1, 8'h13, 4'b1111, 1, 1, 2'd2, 8'h82);
    add(0, 0, 8'h00, 4'b1111, 1, 1, 2'd0, 8'h13);
    // head-of-line blocking: only send_rdy[1] matters
    add(0, 1, 8'h41, 4'b0000, 1, 0, 2'd0, 8'h00);
    for (int i = 0; i < 5; i++)
      add(0, 0, 8'h00, 4'b0100, 1, 1, 2'd1, 8'h41);
    add(0, 0, 8'h00, 4'b0110, 1, 1, 2'd1, 8'h41);
    add(0, 0, 8'h00, 4'b0000, 1, 0, 2'd0, 8'h00);
    // full plus dequeue: no enqueue that cycle, accepted the next
    add(0, 1, 8'h00, 4'b0000, 1, 0, 2'd0, 8'h00);
    add(0, 1, 8'h40, 4'b0000, 1, 1, 2'd0, 8'h00);
    add(0, 1, 8'h81, 4'b1111, 0, 1, 2'd0, 8'h00);
    add(0, 1, 8'h81, 4'b0000, 1, 1, 2'd1, 8'h40);
    add(0, 0, 8'h00, 4'b0000, 0, 1, 2'd1, 8'h40);
    // reset with two queued packets
    add(1, 1, 8'hC5, 4'b1111, 0, 0, 2'd0, 8'h00);
    add(0, 0, 8'h00, 4'b1111, 1, 0, 2'd0, 8'h00);
    add(0, 0, 8'h00, 4'b1111, 1, 0, 2'd0, 8'h00);

    rst4 = 1'b1; val4 = 1'b0; msg4 = 8'h00; srdy4 = 4'b0000;
    rst3 = 1'b1; val3 = 1'b0; msg3 = 8'h00; srdy3 = 3'b000;
    tick();
    tick();

    foreach (vq[i]) begin
      v = vq[i];
      rst4 = v.rst; val4 = v.val; msg4 = v.msg; srdy4 = v.srdy;
      #2;
      $display("vec %0d: rst=%0b val=%0b msg=%02h rdy=%04b -> rr=%0b sv=%0b sel=%0d msg=%02h drop=%0d",
               i, v.rst, v.val, v.msg, v.srdy, rr4, sv4, sel4, smsg4, drop4);
      chk($sformatf("vec%0d recv_rdy", i), int'(rr4), int'(v.e_rr));
      chk($sformatf("vec%0d send_val", i), int'(sv4), int'(v.e_sv));
      chk($sformatf("vec%0d send_sel", i), int'(sel4), int'(v.e_sel));
      chk($sformatf("vec%0d send_msg", i), int'(smsg4), int'(v.e_msg));
      chk($sformatf("vec%0d drop_count", i), int'(drop4), int'(v.e_drop));
      tick();
    end

    // Illegal destination on the 3-output instance: 0xC0 has dest 3.
    rst3 = 1'b0; val3 = 1'b1; msg3 = 8'hC0; srdy3 = 3'b111;
    #2;
    $display("drop seq: push C0 rr=%0b sv=%0b drop=%0d", rr3, sv3, drop3);
    chk("drop3 initial", int'(drop3), 0);
    tick();
    msg3 = 8'h40;
    #2;
    $display("drop seq: head C0, push 40 sv=%0b drop=%0d", sv3, drop3);
    chk("illegal head send_val", int'(sv3), 0);
    chk("illegal head recv_rdy", int'(rr3), 1);
    tick();
    val3 = 1'b0;
    #2;
    $display("drop seq: head 40 sv=%0b sel=%0d msg=%02h drop=%0d", sv3, sel3, smsg3, drop3);
    chk("after drop drop_count", int'(drop3), 1);
    chk("after drop send_val", int'(sv3), 1);
    chk("after drop send_sel", int'(sel3), 1);
    chk("after drop send_msg", int'(smsg3), 8'h40);
    tick();
    #2;
    chk("after send empty", int'(sv3), 0);

    // 256 more illegal packets, one per cycle; counter must saturate.
    drops_seen_val = 0;
    val3 = 1'b1; msg3 = 8'hC0;
    for (int i = 0; i < 256; i++) begin
      tick();
      #2;
      if (sv3) drops_seen_val++;
    end
    val3 = 1'b0;
    tick();
    #2;
    if (sv3) drops_seen_val++;
    tick();
    #2;
    $display("drop seq: after 256 illegal packets drop=%0d sv_hits=%0d", drop3, drops_seen_val);
    chk("illegal never valid", drops_seen_val, 0);
    chk("drop_count saturated", int'(drop3), 255);
    tick();
    #2;
    chk("drop_count holds", int'(drop3), 255);

    // Reset clears the drop counter.
    rst3 = 1'b1;
    #2;
    chk("reset3 recv_rdy low", int'(rr3), 0);
    tick();
    rst3 = 1'b0;
    #2;
    $display("drop seq: after reset rr=%0b drop=%0d", rr3, drop3);
    chk("reset3 drop_count", int'(drop3), 0);
    chk("reset3 recv_rdy", int'(rr3), 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
